// File: rtl/lsu_mem_initiator.sv
// Purpose : load/store initiator between execute and the data cache; one LDR/STR in flight,
//           effective address = base + offset, single-cycle cache request, load data writeback.
// Latency : STR done at accept+2; LDR wb_valid/done at accept+MEM_LAT+2; misaligned fault at accept+1.
// Backpr. : req_ready is high only in IDLE; req_valid is ignored while busy (no queueing).
//
// Ports
//   clock, reset_n                  single clock, async active-low reset
//   req_valid/req_ready/req_*       uop from execute (uop, base, offset, store data, dest reg)
//   mem_uop/mem_addr/mem_wdata      cache request (mem_uop nonzero for exactly one cycle)
//   mem_rd_data                     cache read data, valid MEM_LAT cycles after the request edge
//   wb_valid/wb_rd/wb_data          load writeback (wb_valid is a 1-cycle pulse)
//   done, fault                     1-cycle retire pulse, alignment fault pulse
//
// Optional feature: define LSU_ALIGN_CHECK_EN to fault word-misaligned LDR/STR instead of
// issuing them; without it ea[1:0] is ignored and fault is tied low.

module lsu_mem_initiator #(
  parameter logic [4:0] STR_UOP = 5'b01001,
  parameter logic [4:0] LDR_UOP = 5'b01010,
  parameter int         ADDR_W  = 5,
  parameter int         MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_uop,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_store_data,
  input  logic [3:0]        req_rd,
  output logic [4:0]        mem_uop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rd_data,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              fault
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_ld_q, is_ld_d;
  logic [3:0]         rd_q, rd_d;
  logic               req_ready_q, req_ready_d;
  logic [4:0]         mem_uop_q, mem_uop_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               wb_valid_q, wb_valid_d;
  logic [3:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               done_q, done_d;
`ifdef LSU_ALIGN_CHECK_EN
  logic               fault_q, fault_d;
`endif

  logic [31:0] ea;
  logic        accept;
  logic        is_mem_op;
  logic        unused_ea;

  // 32-bit effective address, carry out dropped.
  assign ea        = req_base + req_offset;
  // req_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept    = req_valid && req_ready_q;
  assign is_mem_op = (req_uop == LDR_UOP) || (req_uop == STR_UOP);
  // High ea bits wrap the cache; byte-offset bits only matter with the alignment check.
  assign unused_ea = ^{ea[31:ADDR_W+2], ea[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_ld_d     = is_ld_q;
    rd_d        = rd_q;
    mem_uop_d   = 5'd0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    fault_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // Non-LDR/STR uops are accepted and silently dropped.
        if (accept && is_mem_op) begin
          is_ld_d     = (req_uop == LDR_UOP);
          rd_d        = req_rd;
          state_d     = S_ISSUE;
          mem_uop_d   = req_uop;
          mem_addr_d  = ea[ADDR_W+1:2];
          mem_wdata_d = req_store_data;
`ifdef LSU_ALIGN_CHECK_EN
          // Misaligned: retire immediately with a fault, cache never sees it.
          if (ea[1:0] != 2'b00) begin
            state_d     = S_RESP;
            mem_uop_d   = 5'd0;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
            done_d      = 1'b1;
            fault_d     = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (is_ld_q) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_d = S_RESP;
          done_d  = 1'b1;
        end
      end
      S_WAIT: begin
        // Read data is captured on the edge that enters RESP.
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          done_d     = 1'b1;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = mem_rd_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_ld_q     <= 1'b0;
      rd_q        <= 4'd0;
      req_ready_q <= 1'b0;
      mem_uop_q   <= 5'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 4'd0;
      wb_data_q   <= 32'd0;
      done_q      <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_ld_q     <= is_ld_d;
      rd_q        <= rd_d;
      req_ready_q <= req_ready_d;
      mem_uop_q   <= mem_uop_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
`ifdef LSU_ALIGN_CHECK_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign mem_uop   = mem_uop_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign fault     = fault_q;
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Purpose : directed self-checking bench for lsu_mem_initiator with a 1-cycle cache model.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : back-to-back requests are offered with req_valid held high.

module tb_lsu_mem_initiator;

  localparam logic [4:0] STR = 5'b01001;
  localparam logic [4:0] LDR = 5'b01010;
  localparam logic [31:0] GARBAGE = 32'h0BAD_F00D;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_uop;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_store_data;
  logic [3:0]  req_rd;
  logic [4:0]  mem_uop;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rd_data;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        fault;

  lsu_mem_initiator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_uop        (req_uop),
    .req_base       (req_base),
    .req_offset     (req_offset),
    .req_store_data (req_store_data),
    .req_rd         (req_rd),
    .mem_uop        (mem_uop),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rd_data    (mem_rd_data),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .done           (done),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Cache model + pulse monitor, evaluated mid-cycle. Load data appears only in the cycle
  // after the request edge; every other cycle carries garbage.
  logic [31:0] mem [32];
  int   n_done  = 0;
  int   n_wb    = 0;
  int   n_fault = 0;
  int   n_b2b   = 0;
  logic prev_nz = 1'b0;
  logic rd_pend = 1'b0;
  logic [4:0] pend_addr = 5'd0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem_rd_data = GARBAGE;
    forever begin
      @(negedge clock);
      if (done)     n_done++;
      if (wb_valid) n_wb++;
      if (fault)    n_fault++;
      if (mem_uop != 5'd0 && prev_nz) n_b2b++;
      prev_nz     = (mem_uop != 5'd0);
      mem_rd_data = rd_pend ? mem[pend_addr] : GARBAGE;
      rd_pend     = (mem_uop == LDR);
      pend_addr   = mem_addr;
      if (mem_uop == STR) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] uop, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] data, input logic [3:0] rd);
    req_valid      = 1'b1;
    req_uop        = uop;
    req_base       = base;
    req_offset     = off;
    req_store_data = data;
    req_rd         = rd;
  endtask

  task automatic run_str(input string tag, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] data, input logic [4:0] exp_addr);
    int w0;
    w0 = n_wb;
    drive(STR, base, off, data, 4'd0);
    step();
    req_valid = 1'b0;
    chk_eq({tag, ".issue_uop"}, 32'(mem_uop), 32'(STR));
    chk_eq({tag, ".issue_addr"}, 32'(mem_addr), 32'(exp_addr));
    chk_eq({tag, ".issue_wdata"}, mem_wdata, data);
    chk_eq({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    step();
    chk_eq({tag, ".resp_done"}, 32'(done), 32'd1);
    chk_eq({tag, ".resp_uop"}, 32'(mem_uop), 32'd0);
    step();
    chk_eq({tag, ".after_done"}, 32'(done), 32'd0);
    chk_eq({tag, ".after_ready"}, 32'(req_ready), 32'd1);
    chk_eq({tag, ".no_wb"}, 32'(n_wb - w0), 32'd0);
  endtask

  task automatic run_ldr(input string tag, input logic [31:0] base, input logic [31:0] off,
                         input logic [3:0] rd, input logic [4:0] exp_addr,
                         input logic [31:0] exp_data);
    drive(LDR, base, off, 32'h5555_AAAA, rd);
    step();
    req_valid = 1'b0;
    chk_eq({tag, ".issue_uop"}, 32'(mem_uop), 32'(LDR));
    chk_eq({tag, ".issue_addr"}, 32'(mem_addr), 32'(exp_addr));
    chk_eq({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    step();
    chk_eq({tag, ".wait_uop"}, 32'(mem_uop), 32'd0);
    chk_eq({tag, ".wait_wb"}, 32'(wb_valid), 32'd0);
    chk_eq({tag, ".wait_done"}, 32'(done), 32'd0);
    step();
    chk_eq({tag, ".resp_wb"}, 32'(wb_valid), 32'd1);
    chk_eq({tag, ".resp_done"}, 32'(done), 32'd1);
    chk_eq({tag, ".resp_data"}, wb_data, exp_data);
    chk_eq({tag, ".resp_rd"}, 32'(wb_rd), 32'(rd));
    step();
    chk_eq({tag, ".after_wb"}, 32'(wb_valid), 32'd0);
    chk_eq({tag, ".after_ready"}, 32'(req_ready), 32'd1);
    chk_eq({tag, ".held_data"}, wb_data, exp_data);
  endtask

  initial begin
    int d0, w0, acc, hi, last, bad;
    logic offered, rdy;

    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_uop        = 5'd0;
    req_base       = 32'd0;
    req_offset     = 32'd0;
    req_store_data = 32'd0;
    req_rd         = 4'd0;

    // Reset state
    repeat (2) step();
    chk_eq("rst.ready", 32'(req_ready), 32'd0);
    chk_eq("rst.uop", 32'(mem_uop), 32'd0);
    chk_eq("rst.done", 32'(done), 32'd0);
    chk_eq("rst.wb", 32'(wb_valid), 32'd0);
    chk_eq("rst.fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
    step();
    chk_eq("rst.ready_after", 32'(req_ready), 32'd1);

    // Store then load back the same word: 0x10+0x4 = 0x14 -> word 5
    run_str("t1", 32'h10, 32'h4, 32'hDEAD_BEEF, 5'd5);
    run_ldr("t2", 32'h10, 32'h4, 4'h3, 5'd5, 32'hDEAD_BEEF);

    // Address wrap: 0x84 -> word 1; 0xFFFFFFFC+8 -> 0x4 -> word 1
    run_ldr("t3a", 32'h7C, 32'h8, 4'h7, 5'd1, 32'h1000_0001);
    run_ldr("t3b", 32'hFFFF_FFFC, 32'h8, 4'hA, 5'd1, 32'h1000_0001);

    // Unknown uop is swallowed without a request or retire
    d0 = n_done;
    drive(5'b00011, 32'h0, 32'h0, 32'h0, 4'h1);
    step();
    req_valid = 1'b0;
    chk_eq("disc.uop", 32'(mem_uop), 32'd0);
    chk_eq("disc.ready", 32'(req_ready), 32'd1);
    repeat (2) step();
    chk_eq("disc.no_done", 32'(n_done - d0), 32'd0);

    // Back-to-back loads with req_valid held: one accept every 4 cycles
    w0 = n_wb; acc = 0; hi = 0; last = -1; bad = 0;
    drive(LDR, 32'h14, 32'h0, 32'h0, 4'h1);
    for (int k = 0; k < 12; k++) begin
      rdy     = req_ready;
      offered = req_valid;
      if (rdy) hi++;
      step();
      if (rdy && offered) begin
        if (last >= 0 && k - last != 4) bad++;
        last = k;
        acc++;
        if (acc == 3) req_valid = 1'b0;
      end
    end
    chk_eq("b2b.accepts", 32'(acc), 32'd3);
    chk_eq("b2b.spacing_err", 32'(bad), 32'd0);
    chk_eq("b2b.ready_cycles", 32'(hi), 32'd3);
    chk_eq("b2b.wb_pulses", 32'(n_wb - w0), 32'd3);
    chk_eq("b2b.last_data", wb_data, 32'hDEAD_BEEF);

    // Reset during WAIT drops the load
    drive(LDR, 32'h14, 32'h0, 32'h0, 4'h2);
    step();
    req_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk_eq("rstw.uop", 32'(mem_uop), 32'd0);
    chk_eq("rstw.ready", 32'(req_ready), 32'd0);
    chk_eq("rstw.addr", 32'(mem_addr), 32'd0);
    chk_eq("rstw.wb_data", wb_data, 32'd0);
    chk_eq("rstw.wb_rd", 32'(wb_rd), 32'd0);
    d0 = n_done;
    w0 = n_wb;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    chk_eq("rstw.no_done", 32'(n_done - d0), 32'd0);
    chk_eq("rstw.no_wb", 32'(n_wb - w0), 32'd0);
    chk_eq("rstw.ready", 32'(req_ready), 32'd1);
    run_ldr("t5", 32'h0, 32'h14, 4'h9, 5'd5, 32'hDEAD_BEEF);

    // Misaligned ea = 0x6
`ifdef LSU_ALIGN_CHECK_EN
    drive(LDR, 32'h4, 32'h2, 32'h0, 4'h4);
    step();
    req_valid = 1'b0;
    chk_eq("t6.fault", 32'(fault), 32'd1);
    chk_eq("t6.done", 32'(done), 32'd1);
    chk_eq("t6.wb", 32'(wb_valid), 32'd0);
    chk_eq("t6.uop", 32'(mem_uop), 32'd0);
    step();
    chk_eq("t6.fault_clr", 32'(fault), 32'd0);
    chk_eq("t6.ready", 32'(req_ready), 32'd1);
    chk_eq("t6.fault_total", 32'(n_fault), 32'd1);
`else
    run_ldr("t6", 32'h4, 32'h2, 4'h4, 5'd1, 32'h1000_0001);
    chk_eq("t6.fault_total", 32'(n_fault), 32'd0);
`endif

    chk_eq("uop_b2b", 32'(n_b2b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
